// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle datapath (12-bit PC, 19-bit IR, 8-bit regs).
// Walks fetch/decode/execute/memory/writeback, drives datapath enables and
// selects, handshakes with a variable-latency memory and traps illegal
// opcodes or memory timeouts into a sticky FAULT state.
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_src,
  output logic       ir_ld,
  output logic       ab_ld,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       aluout_ld,
  output logic       rf_we,
  output logic       rf_wsel,
  output logic       pc_ld,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_FAULT    = 4'd13
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_SUBI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1010;
  localparam logic [3:0] OP_BEZ  = 4'b1011;
  localparam logic [3:0] OP_BNZ  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Last count value tolerated before a missing mem_ready becomes a timeout.
  localparam logic [CNT_W-1:0] WAIT_LIMIT = (MEM_WAIT_MAX == 0) ? {CNT_W{1'b0}}
                                                                : CNT_W'(MEM_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting_s;
  logic             timeout_s;

  assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // mem_ready arriving on the limit cycle takes priority over the timeout.
  assign timeout_s = waiting_s && !mem_ready && (MEM_WAIT_MAX != 0) && (cnt_q == WAIT_LIMIT);

  // State and wait-counter registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sequencing, opcode dispatch and timeout trapping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI:              state_d = S_EXEC_I;
          OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
          OP_JMP:                        state_d = S_JUMP;
          OP_BEZ, OP_BNZ:                state_d = S_BRANCH;
          OP_HALT:                       state_d = S_HALT;
          default:                       state_d = S_FAULT;
        endcase
      end
      S_EXEC_R:   state_d = S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_WB_ALU:   state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_SW) state_d = S_MEM_WR;
        else                 state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (mem_ready)      state_d = S_WB_MEM;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_MEM_RD;
      end
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timeout_s) state_d = S_FAULT;
        else                state_d = S_MEM_WR;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // Wait counter: counts idle cycles in a wait state, cleared on any state change, saturating.
  always_comb begin
    cnt_d = {CNT_W{1'b0}};
    if (waiting_s && !mem_ready && (state_d == state_q)) begin
      if (cnt_q == CNT_SAT) cnt_d = cnt_q;
      else                  cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Output decode from state; ir_ld/pc_ld in FETCH and pc_ld in BRANCH are Mealy.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_src  = 1'b0;
    ir_ld     = 1'b0;
    ab_ld     = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 3'b000;
    aluout_ld = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    pc_ld     = 1'b0;
    pc_src    = 2'b00;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_IDLE: begin
        halted = 1'b0;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_ld  = 1'b1;
          pc_ld  = 1'b1;
          pc_src = 2'b00;
        end else begin
          ir_ld = 1'b0;
          pc_ld = 1'b0;
        end
      end
      S_DECODE: ab_ld = 1'b1;
      S_EXEC_R: begin
        alu_src_b = 1'b0;
        alu_op    = {1'b0, opcode[1:0]};
        aluout_ld = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = (opcode == OP_SUBI) ? 3'b001 : 3'b000;
        aluout_ld = 1'b1;
      end
      S_WB_ALU: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b0;
      end
      S_MEM_ADDR: begin
        alu_src_b = 1'b1;
        alu_op    = 3'b000;
        aluout_ld = 1'b1;
      end
      S_MEM_RD: begin
        mem_rd   = 1'b1;
        addr_src = 1'b1;
      end
      S_WB_MEM: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr   = 1'b1;
        addr_src = 1'b1;
      end
      S_BRANCH: begin
        pc_src = 2'b01;
        if (opcode == OP_BEZ) pc_ld = zero;
        else                  pc_ld = ~zero;
      end
      S_JUMP: begin
        pc_ld  = 1'b1;
        pc_src = 2'b10;
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
    endcase
  end

endmodule
